uplus_eth_link_supervisor: RTL and testbench

Parametrised bring-up and link-health supervisor for the N-channel 10G Ethernet subsystem, running on the free-running DRP clock. Drives the shared QPLL reset and per-channel GT/core resets, waits for QPLL lock with timeout and retry, and debounces each channel's `stat_rx_status` into a clean link-up flag. Watches each enabled link and re-resets only a channel that stays down, without disturbing healthy channels.

---
 rtl/uplus_eth_link_supervisor.sv | 150 +++++++++++++++
 tb/tb_uplus_eth_link_supervisor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uplus_eth_link_supervisor.sv
// uplus_eth_link_supervisor: QPLL/channel reset sequencer with lock retry, link debounce and per-channel watchdog
module uplus_eth_link_supervisor #(
    parameter int unsigned P_CHANNEL_NUM     = 3,
    parameter logic [23:0] P_QPLL_RST_CYCLES = 24'd100,
    parameter logic [23:0] P_CHAN_RST_CYCLES = 24'd100,
    parameter logic [23:0] P_LOCK_TIMEOUT    = 24'd1_000_000,
    parameter logic [23:0] P_LINK_TIMEOUT    = 24'd10_000_000,
    parameter logic [23:0] P_DEBOUNCE        = 24'd1000
) (
    input  logic                     i_dclk,
    input  logic                     i_sys_reset_n,
    input  logic                     i_qpll_lock,
    input  logic [P_CHANNEL_NUM-1:0] i_stat_rx_status,
    input  logic [P_CHANNEL_NUM-1:0] i_chan_enable,
    input  logic                     i_force_reset,
    output logic                     o_qpll_reset,
    output logic [P_CHANNEL_NUM-1:0] o_chan_reset,
    output logic [P_CHANNEL_NUM-1:0] o_link_up,
    output logic                     o_all_link_up,
    output logic [7:0]               o_retry_cnt,
    output logic [2:0]               o_state
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_QPLL_RST  = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_CHAN_RST  = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                   r_state, w_next;
    logic [1:0]               r_lock_sync;
    logic [P_CHANNEL_NUM-1:0] r_stat_s1, r_stat_s2;
    logic [23:0]              r_cnt;
    logic [23:0]              r_db [P_CHANNEL_NUM];
    logic [23:0]              r_wd [P_CHANNEL_NUM];
    logic [P_CHANNEL_NUM-1:0] r_wd_rst;
    logic [23:0]              w_db_nxt [P_CHANNEL_NUM];
    logic [23:0]              w_wd_nxt [P_CHANNEL_NUM];
    logic [P_CHANNEL_NUM-1:0] w_wd_rst_nxt, w_link_nxt, w_chan_rst_nxt;
    logic                     w_lock, w_force, w_restart, w_active, w_retry_inc;

    assign w_lock    = r_lock_sync[1];
    assign w_force   = i_force_reset && (r_state != S_IDLE);
    assign w_restart = w_force || (w_next != r_state);
    assign w_active  = (r_state == S_RUN) && (w_next == S_RUN);
    assign o_state   = r_state;

    // Two-flop synchronisers for the asynchronous lock and link status inputs
    always_ff @(posedge i_dclk or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) begin
            r_lock_sync <= '0;
            r_stat_s1   <= '0;
            r_stat_s2   <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_qpll_lock};
            r_stat_s1   <= i_stat_rx_status;
            r_stat_s2   <= r_stat_s1;
        end
    end

    // Global sequencer next state; force beats lock loss beats lock timeout
    always_comb begin
        w_next      = r_state;
        w_retry_inc = 1'b0;
        case (r_state)
            S_IDLE:      w_next = S_QPLL_RST;
            S_QPLL_RST:  w_next = (r_cnt == P_QPLL_RST_CYCLES - 24'd1) ? S_WAIT_LOCK : S_QPLL_RST;
            S_WAIT_LOCK: begin
                if (w_lock) begin
                    w_next = S_CHAN_RST;
                end else if (r_cnt == P_LOCK_TIMEOUT - 24'd1) begin
                    w_next      = S_QPLL_RST;
                    w_retry_inc = 1'b1;
                end
            end
            S_CHAN_RST:  w_next = (r_cnt == P_CHAN_RST_CYCLES - 24'd1) ? S_RUN : S_CHAN_RST;
            S_RUN: begin
                if (!w_lock) begin
                    w_next      = S_QPLL_RST;
                    w_retry_inc = 1'b1;
                end
            end
            default:     w_next = S_IDLE;
        endcase
        if (w_force) begin
            w_next      = S_QPLL_RST;
            w_retry_inc = 1'b0;
        end
    end

    // Per-channel debounce and watchdog; everything is held cleared unless staying in RUN
    always_comb begin
        for (int i = 0; i < P_CHANNEL_NUM; i++) begin
            w_db_nxt[i]     = (!w_active || !r_stat_s2[i]) ? 24'd0 :
                              (r_db[i] == P_DEBOUNCE) ? r_db[i] : r_db[i] + 24'd1;
            w_link_nxt[i]   = w_active && i_chan_enable[i] && r_stat_s2[i] && (r_db[i] >= P_DEBOUNCE - 24'd1);
            w_wd_rst_nxt[i] = 1'b0;
            w_wd_nxt[i]     = 24'd0;
            if (w_active && i_chan_enable[i]) begin
                if (r_wd_rst[i]) begin
                    w_wd_rst_nxt[i] = (r_wd[i] != P_CHAN_RST_CYCLES - 24'd1);
                    w_wd_nxt[i]     = w_wd_rst_nxt[i] ? r_wd[i] + 24'd1 : 24'd0;
                end else if (!o_link_up[i]) begin
                    w_wd_rst_nxt[i] = (r_wd[i] == P_LINK_TIMEOUT - 24'd1);
                    w_wd_nxt[i]     = w_wd_rst_nxt[i] ? 24'd0 : r_wd[i] + 24'd1;
                end
            end
            w_chan_rst_nxt[i] = (w_next != S_RUN) || !i_chan_enable[i] || w_wd_rst_nxt[i];
        end
    end

    // Sequencer state, phase counter and registered global outputs
    always_ff @(posedge i_dclk or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            o_qpll_reset  <= 1'b1;
            o_retry_cnt   <= '0;
            o_all_link_up <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cnt         <= (w_restart || r_state == S_RUN) ? 24'd0 : r_cnt + 24'd1;
            o_qpll_reset  <= (w_next == S_IDLE) || (w_next == S_QPLL_RST);
            o_retry_cnt   <= (w_retry_inc && o_retry_cnt != 8'hFF) ? o_retry_cnt + 8'd1 : o_retry_cnt;
            o_all_link_up <= (|i_chan_enable) && (&(o_link_up | ~i_chan_enable));
        end
    end

    // Per-channel counters, watchdog pulse flags and registered channel outputs
    always_ff @(posedge i_dclk or negedge i_sys_reset_n) begin
        if (!i_sys_reset_n) begin
            for (int i = 0; i < P_CHANNEL_NUM; i++) begin
                r_db[i] <= '0;
                r_wd[i] <= '0;
            end
            r_wd_rst     <= '0;
            o_link_up    <= '0;
            o_chan_reset <= '1;
        end else begin
            for (int i = 0; i < P_CHANNEL_NUM; i++) begin
                r_db[i] <= w_db_nxt[i];
                r_wd[i] <= w_wd_nxt[i];
            end
            r_wd_rst     <= w_wd_rst_nxt;
            o_link_up    <= w_link_nxt;
            o_chan_reset <= w_chan_rst_nxt;
        end
    end
endmodule

// File: tb/tb_uplus_eth_link_supervisor.sv
// tb_uplus_eth_link_supervisor: cycle-stamped scoreboard bench for the link supervisor
module tb_uplus_eth_link_supervisor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic [2:0] status = 3'b000;
    logic [2:0] en = 3'b111;
    logic       force_rst = 1'b0;
    logic       qpll_reset, all_link_up;
    logic [2:0] chan_reset, link_up, state;
    logic [7:0] retry_cnt;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t  q[$];
    string names[6] = '{"state", "qpll_reset", "chan_reset", "link_up", "all_link_up", "retry_cnt"};

    localparam int ST = 0, QR = 1, CR = 2, LU = 3, AL = 4, RC = 5;

    uplus_eth_link_supervisor #(
        .P_CHANNEL_NUM    (3),
        .P_QPLL_RST_CYCLES(24'd8),
        .P_CHAN_RST_CYCLES(24'd4),
        .P_LOCK_TIMEOUT   (24'd32),
        .P_LINK_TIMEOUT   (24'd64),
        .P_DEBOUNCE       (24'd16)
    ) dut (
        .i_dclk          (clk),
        .i_sys_reset_n   (rst_n),
        .i_qpll_lock     (lock),
        .i_stat_rx_status(status),
        .i_chan_enable   (en),
        .i_force_reset   (force_rst),
        .o_qpll_reset    (qpll_reset),
        .o_chan_reset    (chan_reset),
        .o_link_up       (link_up),
        .o_all_link_up   (all_link_up),
        .o_retry_cnt     (retry_cnt),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int s);
        return (s == ST) ? 32'(state) : (s == QR) ? 32'(qpll_reset) : (s == CR) ? 32'(chan_reset) :
               (s == LU) ? 32'(link_up) : (s == AL) ? 32'(all_link_up) : 32'(retry_cnt);
    endfunction

    task automatic e(input int c, input int s, input logic [31:0] v);
        q.push_back('{c, s, v});
    endtask

    task automatic e_rst(input int c);
        e(c, ST, 0); e(c, QR, 1); e(c, CR, 7); e(c, LU, 0); e(c, AL, 0); e(c, RC, 0);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                n_vec++;
                if (actual(q[i].sel) !== q[i].val) begin
                    n_err++;
                    $display("FAIL %s @cycle %0d: got %0h expected %0h", names[q[i].sel], cyc, actual(q[i].sel), q[i].val);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        e_rst(1);
        wait_to(3);
        rst_n = 1'b1;
        e_rst(3);
        e(4, ST, 1); e(11, QR, 1); e(11, ST, 1); e(12, ST, 2); e(12, QR, 0);
        wait_to(16);
        lock = 1'b1;
        e(18, ST, 2); e(19, ST, 3); e(22, ST, 3); e(22, CR, 7); e(23, ST, 4); e(23, CR, 0);
        wait_to(23);
        status = 3'b111;
        e(40, LU, 0); e(41, LU, 7); e(41, AL, 0); e(42, AL, 1); e(42, RC, 0);
        wait_to(50);
        status = 3'b101;
        wait_to(51);
        status = 3'b111;
        e(52, LU, 7); e(53, LU, 5); e(53, AL, 1); e(54, AL, 0); e(60, CR, 0);
        e(68, LU, 5); e(69, LU, 7); e(69, CR, 0); e(70, AL, 1);
        wait_to(80);
        status = 3'b011;
        e(82, LU, 7); e(83, LU, 3); e(146, CR, 0); e(147, CR, 4); e(150, CR, 4); e(151, CR, 0);
        e(200, ST, 4); e(214, CR, 0); e(215, CR, 4); e(218, CR, 4); e(219, CR, 0);
        e(282, CR, 0); e(282, ST, 4);
        wait_to(282);
        force_rst = 1'b1;
        wait_to(283);
        force_rst = 1'b0;
        e(283, ST, 1); e(283, QR, 1); e(283, CR, 7); e(283, LU, 0); e(283, RC, 0);
        e(290, ST, 1); e(291, ST, 2); e(291, QR, 0); e(292, ST, 3); e(296, ST, 4); e(296, CR, 0);
        wait_to(296);
        status = 3'b111;
        e(311, LU, 0); e(312, LU, 3); e(313, LU, 3); e(314, LU, 7); e(314, AL, 0); e(315, AL, 1);
        wait_to(330);
        lock = 1'b0;
        e(332, ST, 4); e(333, ST, 1); e(333, LU, 0); e(333, RC, 1); e(333, AL, 1); e(333, CR, 7);
        e(333, QR, 1); e(334, AL, 0);
        e(372, ST, 2); e(372, RC, 1); e(373, ST, 1); e(373, RC, 2); e(412, RC, 2); e(413, RC, 3);
        e(10453, RC, 254); e(10492, RC, 254); e(10493, RC, 255); e(12333, RC, 255); e(12333, ST, 1);
        wait_to(12333);
        lock = 1'b1;
        en = 3'b101;
        status = 3'b101;
        e(12345, CR, 7); e(12346, CR, 2); e(12346, ST, 4); e(12346, RC, 255);
        e(12361, LU, 0); e(12362, LU, 5); e(12362, AL, 0); e(12363, AL, 1); e(12370, CR, 2);
        e(12379, ST, 4); e(12379, AL, 1);
        wait_to(12380);
        e_rst(12380);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec += 6;
        if (state !== 3'd0) begin
            n_err++;
            $display("FAIL async state: got %0h", state);
        end
        if (qpll_reset !== 1'b1) begin
            n_err++;
            $display("FAIL async qpll_reset: got %0h", qpll_reset);
        end
        if (chan_reset !== 3'b111) begin
            n_err++;
            $display("FAIL async chan_reset: got %0h", chan_reset);
        end
        if (link_up !== 3'b000) begin
            n_err++;
            $display("FAIL async link_up: got %0h", link_up);
        end
        if (all_link_up !== 1'b0) begin
            n_err++;
            $display("FAIL async all_link_up: got %0h", all_link_up);
        end
        if (retry_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL async retry_cnt: got %0h", retry_cnt);
        end
        wait_to(12383);
        rst_n = 1'b1;
        e(12383, ST, 0); e(12383, CR, 7); e(12384, ST, 1); e(12384, RC, 0);
        wait_to(12390);
        foreach (q[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s @cycle %0d: never compared, expected %0h", names[q[i].sel], q[i].cyc, q[i].val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
